// File: rtl/memory_arbiter.sv
// memory_arbiter
//
// Controller and round-robin arbiter for one 64-word PE memory with a single
// synchronous access port. Two requesters share the port: the loader (A) and
// the PE compute side (B). The block sequences the memory's write, read and
// whole-array clear modes, and returns read data with a one-cycle valid strobe.
// All outputs are registered.
//
// Ports
//   w_clk, w_rst_n              clock, synchronous active-low reset
//   w_a_* / w_b_*               requester req, rw (1 = write), address, write data
//   r_a_grant / r_b_grant       one-cycle pulse when the request is accepted
//   r_a_valid / r_b_valid       one-cycle pulse when read data is available
//   r_a_data_out / r_b_data_out last read result, held until that requester's next read
//   w_clear_req / r_clear_done  whole-memory clear request / completion pulse
//   r_mem_ready                 0 clears the memory array on the next edge
//   r_mem_rw                    1 stores on each edge, 0 loads the read register
//   r_mem_address               memory word address
//   r_mem_data_in               memory write data
//   w_mem_data_out              memory read register

module memory_arbiter #(
  parameter int num_bits = 8
) (
  input  logic                w_clk,
  input  logic                w_rst_n,
  input  logic                w_a_req,
  input  logic                w_a_rw,
  input  logic [5:0]          w_a_address,
  input  logic [num_bits-1:0] w_a_data_in,
  input  logic                w_b_req,
  input  logic                w_b_rw,
  input  logic [5:0]          w_b_address,
  input  logic [num_bits-1:0] w_b_data_in,
  output logic                r_a_grant,
  output logic                r_b_grant,
  output logic                r_a_valid,
  output logic                r_b_valid,
  output logic [num_bits-1:0] r_a_data_out,
  output logic [num_bits-1:0] r_b_data_out,
  input  logic                w_clear_req,
  output logic                r_clear_done,
  output logic                r_mem_ready,
  output logic                r_mem_rw,
  output logic [5:0]          r_mem_address,
  output logic [num_bits-1:0] r_mem_data_in,
  input  logic [num_bits-1:0] w_mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;       // 0 = A next on a tie, 1 = B next
  logic                owner_q, owner_d;   // 0 = A, 1 = B owns the access in flight
  logic                a_grant_q, a_grant_d;
  logic                b_grant_q, b_grant_d;
  logic                a_valid_q, a_valid_d;
  logic                b_valid_q, b_valid_d;
  logic [num_bits-1:0] a_data_out_q, a_data_out_d;
  logic [num_bits-1:0] b_data_out_q, b_data_out_d;
  logic                clear_done_q, clear_done_d;
  logic                mem_ready_q, mem_ready_d;
  logic                mem_rw_q, mem_rw_d;
  logic [5:0]          mem_address_q, mem_address_d;
  logic [num_bits-1:0] mem_data_in_q, mem_data_in_d;

  // Arbitration result for the current inputs
  logic accept;
  logic pick_b;
  logic sel_rw;

  // State register plus every registered output. Reset holds r_mem_ready low
  // so the memory array is wiped for as long as reset is asserted.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      owner_q       <= 1'b0;
      a_grant_q     <= 1'b0;
      b_grant_q     <= 1'b0;
      a_valid_q     <= 1'b0;
      b_valid_q     <= 1'b0;
      a_data_out_q  <= '0;
      b_data_out_q  <= '0;
      clear_done_q  <= 1'b0;
      mem_ready_q   <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      a_grant_q     <= a_grant_d;
      b_grant_q     <= b_grant_d;
      a_valid_q     <= a_valid_d;
      b_valid_q     <= b_valid_d;
      a_data_out_q  <= a_data_out_d;
      b_data_out_q  <= b_data_out_d;
      clear_done_q  <= clear_done_d;
      mem_ready_q   <= mem_ready_d;
      mem_rw_q      <= mem_rw_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  // Next-state logic. A lone requester always wins; on a tie the round-robin
  // pointer decides. A pending clear outranks both requesters in IDLE.
  always_comb begin
    accept = 1'b0;
    pick_b = 1'b0;
    if (w_a_req && w_b_req) begin
      accept = 1'b1;
      pick_b = ptr_q;
    end else if (w_a_req) begin
      accept = 1'b1;
      pick_b = 1'b0;
    end else if (w_b_req) begin
      accept = 1'b1;
      pick_b = 1'b1;
    end
    sel_rw = pick_b ? w_b_rw : w_a_rw;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_clear_req) begin
          state_d = CLEAR;
        end else if (accept) begin
          state_d = sel_rw ? WRITE : READ;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: computes the value every registered output takes in the
  // next cycle. r_mem_rw can only become 1 on the way into WRITE, so the
  // memory never stores outside that single cycle. Read data is steered to
  // the owner only, leaving the other requester's result untouched.
  always_comb begin
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    a_grant_d     = 1'b0;
    b_grant_d     = 1'b0;
    a_valid_d     = 1'b0;
    b_valid_d     = 1'b0;
    a_data_out_d  = a_data_out_q;
    b_data_out_d  = b_data_out_q;
    clear_done_d  = 1'b0;
    mem_ready_d   = (state_d != CLEAR);
    mem_rw_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;

    case (state_q)
      IDLE: begin
        if (!w_clear_req && accept) begin
          mem_rw_d      = sel_rw;
          mem_address_d = pick_b ? w_b_address : w_a_address;
          mem_data_in_d = pick_b ? w_b_data_in : w_a_data_in;
          owner_d       = pick_b;
          ptr_d         = ~pick_b;
          a_grant_d     = ~pick_b;
          b_grant_d     = pick_b;
        end
      end
      CAPTURE: begin
        if (owner_q) begin
          b_data_out_d = w_mem_data_out;
          b_valid_d    = 1'b1;
        end else begin
          a_data_out_d = w_mem_data_out;
          a_valid_d    = 1'b1;
        end
      end
      CLEAR: begin
        clear_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign r_a_grant     = a_grant_q;
  assign r_b_grant     = b_grant_q;
  assign r_a_valid     = a_valid_q;
  assign r_b_valid     = b_valid_q;
  assign r_a_data_out  = a_data_out_q;
  assign r_b_data_out  = b_data_out_q;
  assign r_clear_done  = clear_done_q;
  assign r_mem_ready   = mem_ready_q;
  assign r_mem_rw      = mem_rw_q;
  assign r_mem_address = mem_address_q;
  assign r_mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//
// Directed bench for memory_arbiter. Two instances are built: an 8-bit one
// driving most of the sequence and a 16-bit one for the wide data path. Each
// is paired with a behavioural model of the 64-word memory it controls.

module tb_memory_arbiter;

  logic w_clk;
  logic w_rst_n;

  // 8-bit instance signals
  logic       a_req, a_rw, b_req, b_rw, clear_req;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_din, b_din;
  logic       a_grant, b_grant, a_valid, b_valid, clear_done;
  logic [7:0] a_dout, b_dout;
  logic       mem_ready, mem_rw;
  logic [5:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  // 16-bit instance signals
  logic        a16_req, a16_rw, b16_req, b16_rw;
  logic [5:0]  a16_addr, b16_addr;
  logic [15:0] a16_din, b16_din;
  logic        a16_grant, b16_grant, a16_valid, b16_valid, clear16_done;
  logic [15:0] a16_dout, b16_dout;
  logic        mem16_ready, mem16_rw;
  logic [5:0]  mem16_addr;
  logic [15:0] mem16_din;
  logic [15:0] mem16_dout;

  int pass_count  = 0;
  int check_count = 0;

  memory_arbiter #(.num_bits(8)) dut (
    .w_clk          (w_clk),
    .w_rst_n        (w_rst_n),
    .w_a_req        (a_req),
    .w_a_rw         (a_rw),
    .w_a_address    (a_addr),
    .w_a_data_in    (a_din),
    .w_b_req        (b_req),
    .w_b_rw         (b_rw),
    .w_b_address    (b_addr),
    .w_b_data_in    (b_din),
    .r_a_grant      (a_grant),
    .r_b_grant      (b_grant),
    .r_a_valid      (a_valid),
    .r_b_valid      (b_valid),
    .r_a_data_out   (a_dout),
    .r_b_data_out   (b_dout),
    .w_clear_req    (clear_req),
    .r_clear_done   (clear_done),
    .r_mem_ready    (mem_ready),
    .r_mem_rw       (mem_rw),
    .r_mem_address  (mem_addr),
    .r_mem_data_in  (mem_din),
    .w_mem_data_out (mem_dout)
  );

  memory_arbiter #(.num_bits(16)) dut16 (
    .w_clk          (w_clk),
    .w_rst_n        (w_rst_n),
    .w_a_req        (a16_req),
    .w_a_rw         (a16_rw),
    .w_a_address    (a16_addr),
    .w_a_data_in    (a16_din),
    .w_b_req        (b16_req),
    .w_b_rw         (b16_rw),
    .w_b_address    (b16_addr),
    .w_b_data_in    (b16_din),
    .r_a_grant      (a16_grant),
    .r_b_grant      (b16_grant),
    .r_a_valid      (a16_valid),
    .r_b_valid      (b16_valid),
    .r_a_data_out   (a16_dout),
    .r_b_data_out   (b16_dout),
    .w_clear_req    (1'b0),
    .r_clear_done   (clear16_done),
    .r_mem_ready    (mem16_ready),
    .r_mem_rw       (mem16_rw),
    .r_mem_address  (mem16_addr),
    .r_mem_data_in  (mem16_din),
    .w_mem_data_out (mem16_dout)
  );

  // Free-running clock, 10 time units per period
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Behavioural model of the 8-bit memory: clear when not ready, store when
  // rw is high, otherwise load the read register.
  logic [7:0] mem8 [64];
  logic [7:0] rd8 = '0;
  assign mem_dout = rd8;
  always @(posedge w_clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem8[i] <= '0;
    end else if (mem_rw) begin
      mem8[mem_addr] <= mem_din;
    end else begin
      rd8 <= mem8[mem_addr];
    end
  end

  // Same memory model, 16-bit words
  logic [15:0] mem16 [64];
  logic [15:0] rd16 = '0;
  assign mem16_dout = rd16;
  always @(posedge w_clk) begin
    if (!mem16_ready) begin
      for (int i = 0; i < 64; i++) mem16[i] <= '0;
    end else if (mem16_rw) begin
      mem16[mem16_addr] <= mem16_din;
    end else begin
      rd16 <= mem16[mem16_addr];
    end
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  // Drive all request inputs of the 8-bit instance
  task automatic applyStimulus(input logic ar, input logic arw, input logic [5:0] aad,
                               input logic [7:0] ad, input logic br, input logic brw,
                               input logic [5:0] bad, input logic [7:0] bd,
                               input logic clr);
    a_req     = ar;
    a_rw      = arw;
    a_addr    = aad;
    a_din     = ad;
    b_req     = br;
    b_rw      = brw;
    b_addr    = bad;
    b_din     = bd;
    clear_req = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " mem_ready"}, 32'(mem_ready), 32'd0);
    checkOutput({tag, " mem_rw"}, 32'(mem_rw), 32'd0);
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, " mem_din"}, 32'(mem_din), 32'd0);
    checkOutput({tag, " grants"}, {30'd0, a_grant, b_grant}, 32'd0);
    checkOutput({tag, " valids"}, {30'd0, a_valid, b_valid}, 32'd0);
    checkOutput({tag, " clear_done"}, 32'(clear_done), 32'd0);
    checkOutput({tag, " a_dout"}, 32'(a_dout), 32'd0);
    checkOutput({tag, " b_dout"}, 32'(b_dout), 32'd0);
    checkOutput({tag, " mem16_ready"}, 32'(mem16_ready), 32'd0);
  endtask

  // Directed sequence
  initial begin
    w_rst_n  = 1'b0;
    a16_req  = 1'b0; a16_rw = 1'b0; a16_addr = '0; a16_din = '0;
    b16_req  = 1'b0; b16_rw = 1'b0; b16_addr = '0; b16_din = '0;
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    tick();
    checkResetState("reset");

    // A writes 0x5A to address 3 on the very first edge out of reset
    w_rst_n = 1'b1;
    applyStimulus(1, 1, 6'd3, 8'h5A, 0, 0, 6'd0, 8'h00, 0);
    tick();
    checkOutput("wr a_grant", 32'(a_grant), 32'd1);
    checkOutput("wr b_grant", 32'(b_grant), 32'd0);
    checkOutput("wr mem_rw", 32'(mem_rw), 32'd1);
    checkOutput("wr mem_addr", 32'(mem_addr), 32'd3);
    checkOutput("wr mem_din", 32'(mem_din), 32'h5A);
    checkOutput("wr mem_ready", 32'(mem_ready), 32'd1);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    checkOutput("wr committed", 32'(mem8[3]), 32'h5A);
    checkOutput("wr idle rw", 32'(mem_rw), 32'd0);
    checkOutput("wr grant end", 32'(a_grant), 32'd0);

    // A reads address 3
    applyStimulus(1, 0, 6'd3, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    checkOutput("rd a_grant", 32'(a_grant), 32'd1);
    checkOutput("rd mem_rw", 32'(mem_rw), 32'd0);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    checkOutput("rd no early valid", 32'(a_valid), 32'd0);
    tick();
    checkOutput("rd a_valid", 32'(a_valid), 32'd1);
    checkOutput("rd a_dout", 32'(a_dout), 32'h5A);
    checkOutput("rd b_valid", 32'(b_valid), 32'd0);

    // Reset so the pointer is back at A, then B writes 0xC3 to address 0
    w_rst_n = 1'b0;
    tick();
    w_rst_n = 1'b1;
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 1, 6'd0, 8'hC3, 0);
    tick();
    checkOutput("bwr b_grant", 32'(b_grant), 32'd1);
    checkOutput("bwr a_grant", 32'(a_grant), 32'd0);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    checkOutput("bwr committed", 32'(mem8[0]), 32'hC3);

    // Both hold read requests for address 0; the last grant was B, so A goes first
    applyStimulus(1, 0, 6'd0, 8'h00, 1, 0, 6'd0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      logic b_turn;
      b_turn = (i % 2) == 1;
      tick();
      checkOutput($sformatf("rr%0d a_grant", i), 32'(a_grant), 32'(!b_turn));
      checkOutput($sformatf("rr%0d b_grant", i), 32'(b_grant), 32'(b_turn));
      tick();
      tick();
      checkOutput($sformatf("rr%0d a_valid", i), 32'(a_valid), 32'(!b_turn));
      checkOutput($sformatf("rr%0d b_valid", i), 32'(b_valid), 32'(b_turn));
      checkOutput($sformatf("rr%0d a_dout", i), 32'(a_dout), 32'hC3);
      checkOutput($sformatf("rr%0d b_dout", i), 32'(b_dout), (i >= 1) ? 32'hC3 : 32'h00);
    end
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);

    // A writes 0xFF to addresses 0 and 63
    applyStimulus(1, 1, 6'd0, 8'hFF, 0, 0, 6'd0, 8'h00, 0);
    tick();
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    applyStimulus(1, 1, 6'd63, 8'hFF, 0, 0, 6'd0, 8'h00, 0);
    tick();
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    checkOutput("ff addr0", 32'(mem8[0]), 32'hFF);
    checkOutput("ff addr63", 32'(mem8[63]), 32'hFF);

    // Clear raised together with a B read of address 63: clear goes first
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 0, 6'd63, 8'h00, 1);
    tick();
    checkOutput("clr mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("clr b_grant", 32'(b_grant), 32'd0);
    checkOutput("clr early done", 32'(clear_done), 32'd0);
    tick();
    checkOutput("clr ready back", 32'(mem_ready), 32'd1);
    checkOutput("clr done", 32'(clear_done), 32'd1);
    checkOutput("clr addr63", 32'(mem8[63]), 32'h00);
    checkOutput("clr addr0", 32'(mem8[0]), 32'h00);
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 0, 6'd63, 8'h00, 0);
    tick();
    checkOutput("clr then b_grant", 32'(b_grant), 32'd1);
    checkOutput("clr done pulse", 32'(clear_done), 32'd0);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    tick();
    checkOutput("clr b_valid", 32'(b_valid), 32'd1);
    checkOutput("clr b_dout", 32'(b_dout), 32'h00);
    checkOutput("clr a_valid", 32'(a_valid), 32'd0);

    // Back-to-back B writes with req held high the whole time
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 6'd0, 8'h00, 1, 1, 6'(20 + k), 8'(17 * (k + 1)), 0);
      tick();
      checkOutput($sformatf("b2b%0d b_grant", k), 32'(b_grant), 32'd1);
      checkOutput($sformatf("b2b%0d mem_rw", k), 32'(mem_rw), 32'd1);
      checkOutput($sformatf("b2b%0d mem_addr", k), 32'(mem_addr), 32'(20 + k));
      tick();
      checkOutput($sformatf("b2b%0d gap grant", k), 32'(b_grant), 32'd0);
      checkOutput($sformatf("b2b%0d idle rw", k), 32'(mem_rw), 32'd0);
    end
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    checkOutput("b2b mem20", 32'(mem8[20]), 32'h11);
    checkOutput("b2b mem21", 32'(mem8[21]), 32'h22);
    checkOutput("b2b mem22", 32'(mem8[22]), 32'h33);

    // A read of address 20, reset asserted during CAPTURE
    applyStimulus(1, 0, 6'd20, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    checkOutput("rst a_grant", 32'(a_grant), 32'd1);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 0);
    tick();
    w_rst_n = 1'b0;
    tick();
    checkResetState("midrst");
    tick();
    checkOutput("midrst held ready", 32'(mem_ready), 32'd0);
    checkOutput("midrst held valid", 32'(a_valid), 32'd0);
    w_rst_n = 1'b1;
    tick();
    checkOutput("midrst ready up", 32'(mem_ready), 32'd1);
    checkOutput("midrst no valid", 32'(a_valid), 32'd0);
    checkOutput("midrst a_dout", 32'(a_dout), 32'd0);

    // 16-bit instance: B writes 0xBEEF to address 10, A reads it back
    b16_req = 1'b1; b16_rw = 1'b1; b16_addr = 6'd10; b16_din = 16'hBEEF;
    tick();
    checkOutput("w16 b_grant", 32'(b16_grant), 32'd1);
    b16_req = 1'b0; b16_rw = 1'b0;
    tick();
    checkOutput("w16 committed", 32'(mem16[10]), 32'hBEEF);
    a16_req = 1'b1; a16_rw = 1'b0; a16_addr = 6'd10;
    tick();
    checkOutput("r16 a_grant", 32'(a16_grant), 32'd1);
    a16_req = 1'b0;
    tick();
    tick();
    checkOutput("r16 a_valid", 32'(a16_valid), 32'd1);
    checkOutput("r16 a_dout", 32'(a16_dout), 32'hBEEF);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
